// File: rtl/dmem_port_arbiter_if.sv
// Bundle of fetch, data-stage and memory-port signals around the port arbiter.
// Latency: none (wires only).
// Backpressure: fetch/load hold enables until ready; stores are held off by d_stall_out.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch stage
  logic              i_rd_enable;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic              i_rd_ready;
  // memory stage
  logic              d_rd_enable;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_rd_data;
  logic              d_rd_ready;
  logic              d_wr_enable;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic [1:0]        d_wr_size;
  logic              d_stall_out;
  // backing memory port
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic [1:0]        m_wr_size;
  logic              m_rd_enable;
  logic              m_wr_enable;
  logic [DATA_W-1:0] m_rd_data;
  logic              m_ready;
  // control / status
  logic              flush;
  logic              bus_error;
  logic              bus_error_src;

  // arbiter side
  modport slave (
    input  i_rd_enable, i_addr, d_rd_enable, d_addr,
           d_wr_enable, d_wr_addr, d_wr_data, d_wr_size,
           m_rd_data, m_ready, flush,
    output i_rd_data, i_rd_ready, d_rd_data, d_rd_ready, d_stall_out,
           m_addr, m_wr_data, m_wr_size, m_rd_enable, m_wr_enable,
           bus_error, bus_error_src
  );

  // pipeline + memory side
  modport master (
    output i_rd_enable, i_addr, d_rd_enable, d_addr,
           d_wr_enable, d_wr_addr, d_wr_data, d_wr_size,
           m_rd_data, m_ready, flush,
    input  i_rd_data, i_rd_ready, d_rd_data, d_rd_ready, d_stall_out,
           m_addr, m_wr_data, m_wr_size, m_rd_enable, m_wr_enable,
           bus_error, bus_error_src
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one memory port between fetch reads and memory-stage loads/stores.
// Latency: grant edge + one edge per memory cycle; read ready one cycle after m_ready.
// Backpressure: reads held by level enables, stores stall via a one-entry write buffer.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_port_arbiter_if.slave    bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              kill_q, kill_d;
  logic              wbuf_valid_q, wbuf_valid_d;
  logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [DATA_W-1:0] wbuf_data_q, wbuf_data_d;
  logic [1:0]        wbuf_size_q, wbuf_size_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wr_data_q, m_wr_data_d;
  logic [1:0]        m_wr_size_q, m_wr_size_d;
  logic              m_rd_en_q, m_rd_en_d;
  logic              m_wr_en_q, m_wr_en_d;
  logic [DATA_W-1:0] i_rd_data_q, i_rd_data_d;
  logic              i_rd_ready_q, i_rd_ready_d;
  logic [DATA_W-1:0] d_rd_data_q, d_rd_data_d;
  logic              d_rd_ready_q, d_rd_ready_d;
  logic              bus_error_q, bus_error_d;
  logic              bus_error_src_q, bus_error_src_d;

  logic i_ok, d_ok, done, expire, drain;

  // Next-state: grant selection in IDLE, completion/abort in busy states, store capture.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_d_d        = last_d_q;
    kill_d          = kill_q;
    wbuf_valid_d    = wbuf_valid_q;
    wbuf_addr_d     = wbuf_addr_q;
    wbuf_data_d     = wbuf_data_q;
    wbuf_size_d     = wbuf_size_q;
    m_addr_d        = m_addr_q;
    m_wr_data_d     = m_wr_data_q;
    m_wr_size_d     = m_wr_size_q;
    m_rd_en_d       = m_rd_en_q;
    m_wr_en_d       = m_wr_en_q;
    i_rd_data_d     = i_rd_data_q;
    i_rd_ready_d    = 1'b0;
    d_rd_data_d     = d_rd_data_q;
    d_rd_ready_d    = 1'b0;
    bus_error_d     = 1'b0;
    bus_error_src_d = bus_error_src_q;
    drain           = 1'b0;
    // a requester whose ready is pulsing this cycle is still holding its old enable
    i_ok            = bus.i_rd_enable && !i_rd_ready_q;
    d_ok            = bus.d_rd_enable && !d_rd_ready_q;
    done            = bus.m_ready;
    expire          = (TIMEOUT != 0) && !bus.m_ready && (cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        kill_d = 1'b0;
        if (wbuf_valid_q) begin
          // buffered store first, so it lands before any later load
          state_d     = WR;
          m_addr_d    = wbuf_addr_q;
          m_wr_data_d = wbuf_data_q;
          m_wr_size_d = wbuf_size_q;
          m_wr_en_d   = 1'b1;
          last_d_d    = 1'b1;
        end else if (i_ok && (!d_ok || last_d_q)) begin
          state_d   = RD_I;
          m_addr_d  = bus.i_addr;
          m_rd_en_d = 1'b1;
          last_d_d  = 1'b0;
        end else if (d_ok) begin
          state_d   = RD_D;
          m_addr_d  = bus.d_addr;
          m_rd_en_d = 1'b1;
          last_d_d  = 1'b1;
        end
      end
      default: begin
        cnt_d  = cnt_q + 1'b1;
        // a flush seen at any busy edge swallows the read's ready pulse
        kill_d = kill_q | bus.flush;
        if (done || expire) begin
          state_d   = IDLE;
          m_rd_en_d = 1'b0;
          m_wr_en_d = 1'b0;
          if (expire) begin
            bus_error_d     = 1'b1;
            bus_error_src_d = (state_q != RD_I);
          end
          if (state_q == RD_I && !kill_d) begin
            i_rd_ready_d = 1'b1;
            i_rd_data_d  = done ? bus.m_rd_data : '0;
          end
          if (state_q == RD_D && !kill_d) begin
            d_rd_ready_d = 1'b1;
            d_rd_data_d  = done ? bus.m_rd_data : '0;
          end
          if (state_q == WR) begin
            drain = 1'b1;
          end
        end
      end
    endcase

    if (drain) begin
      wbuf_valid_d = 1'b0;
    end
    // a store pulse is taken if the buffer is empty or empties on this edge;
    // an overrun is reported as a data-side error and wins over a same-edge fetch abort
    if (bus.d_wr_enable) begin
      if (!wbuf_valid_q || drain) begin
        wbuf_valid_d = 1'b1;
        wbuf_addr_d  = bus.d_wr_addr;
        wbuf_data_d  = bus.d_wr_data;
        wbuf_size_d  = bus.d_wr_size;
      end else begin
        bus_error_d     = 1'b1;
        bus_error_src_d = 1'b1;
      end
    end
  end

  // State registers; async reset drops the memory request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      last_d_q        <= 1'b1;
      kill_q          <= 1'b0;
      wbuf_valid_q    <= 1'b0;
      wbuf_addr_q     <= '0;
      wbuf_data_q     <= '0;
      wbuf_size_q     <= '0;
      m_addr_q        <= '0;
      m_wr_data_q     <= '0;
      m_wr_size_q     <= '0;
      m_rd_en_q       <= 1'b0;
      m_wr_en_q       <= 1'b0;
      i_rd_data_q     <= '0;
      i_rd_ready_q    <= 1'b0;
      d_rd_data_q     <= '0;
      d_rd_ready_q    <= 1'b0;
      bus_error_q     <= 1'b0;
      bus_error_src_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_d_q        <= last_d_d;
      kill_q          <= kill_d;
      wbuf_valid_q    <= wbuf_valid_d;
      wbuf_addr_q     <= wbuf_addr_d;
      wbuf_data_q     <= wbuf_data_d;
      wbuf_size_q     <= wbuf_size_d;
      m_addr_q        <= m_addr_d;
      m_wr_data_q     <= m_wr_data_d;
      m_wr_size_q     <= m_wr_size_d;
      m_rd_en_q       <= m_rd_en_d;
      m_wr_en_q       <= m_wr_en_d;
      i_rd_data_q     <= i_rd_data_d;
      i_rd_ready_q    <= i_rd_ready_d;
      d_rd_data_q     <= d_rd_data_d;
      d_rd_ready_q    <= d_rd_ready_d;
      bus_error_q     <= bus_error_d;
      bus_error_src_q <= bus_error_src_d;
    end
  end

  assign bus.i_rd_data     = i_rd_data_q;
  assign bus.i_rd_ready    = i_rd_ready_q;
  assign bus.d_rd_data     = d_rd_data_q;
  assign bus.d_rd_ready    = d_rd_ready_q;
  assign bus.d_stall_out   = wbuf_valid_q;
  assign bus.m_addr        = m_addr_q;
  assign bus.m_wr_data     = m_wr_data_q;
  assign bus.m_wr_size     = m_wr_size_q;
  assign bus.m_rd_enable   = m_rd_en_q;
  assign bus.m_wr_enable   = m_wr_en_q;
  assign bus.bus_error     = bus_error_q;
  assign bus.bus_error_src = bus_error_src_q;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single backing data/instruction memory port between the fetch stage (reads) and the memory stage (loads and stores). It sequences one memory transaction at a time over a hold-until-ready handshake and buffers one store so the memory stage's one-cycle write pulse is never lost. It orders stores before later loads and alternates grants between stages. A watchdog aborts transactions the memory never answers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles waiting for m_ready before abort; 0 disables watchdog
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_rd_enable  in  1  fetch read request, level, held until i_rd_ready
- i_addr  in  ADDR_W  fetch address, stable while i_rd_enable high
- i_rd_data  out  DATA_W  fetch read data, valid when i_rd_ready high
- i_rd_ready  out  1  one-cycle completion pulse for fetch
- d_rd_enable  in  1  load request, level, held until d_rd_ready
- d_addr  in  ADDR_W  load address
- d_rd_data  out  DATA_W  raw load word; sign/size adjust stays in memory stage
- d_rd_ready  out  1  one-cycle completion pulse for loads
- d_wr_enable  in  1  store pulse, one cycle per store
- d_wr_addr / d_wr_data  in  ADDR_W / DATA_W  store address / data, sampled with pulse
- d_wr_size  in  2  store size (funct[1:0]), passed through
- d_stall_out  out  1  write buffer occupied; memory stage must not issue another store
- m_addr, m_wr_data, m_wr_size  out  ADDR_W, DATA_W, 2  memory port, registered
- m_rd_enable, m_wr_enable  out  1  memory request, held until m_ready sampled high
- m_rd_data  in  DATA_W  memory read data, valid with m_ready
- m_ready  in  1  memory completion
- flush  in  1  pipeline flush
- bus_error  out  1  one-cycle pulse on timeout or store overrun
- bus_error_src  out  1  0 = fetch, 1 = data; valid with bus_error

## Operation
- State machine: IDLE, RD_I, RD_D, WR.
- Write buffer: one entry (wbuf_valid, addr, data, size).
  - A d_wr_enable pulse is captured at the edge if the buffer is empty, or if it drains on that same edge.
  - A pulse while the buffer is full and not draining is dropped. It raises bus_error with src=1.
- IDLE grant order, evaluated at each edge:
  - The buffered store always wins, so a store precedes any load issued after it.
  - Otherwise, if both reads are eligible, grant the class not granted last (flag last_d). last_d resets to 1, so fetch wins first.
  - Otherwise grant the single eligible read.
  - WR counts as a D grant.
- A requester is ineligible in any cycle where its own rd_ready is high. This turnaround mask prevents a held enable from re-issuing.
- On grant: register m_addr (plus m_wr_data and m_wr_size for WR). Assert m_rd_enable or m_wr_enable and enter the busy state. Clear the watchdog counter.
- Busy state:
  - On an edge with m_ready=1: deassert enables and return to IDLE.
  - For a read, register m_rd_data into x_rd_data and pulse x_rd_ready.
  - For WR, clear wbuf_valid.
- Watchdog: counts busy cycles. On reaching TIMEOUT without m_ready, abort: deassert enables, return to IDLE, pulse bus_error with src.
  - Aborted read: x_rd_data=0, x_rd_ready pulsed.
  - Aborted write: buffer cleared.
- flush:
  - An in-flight read completes on the memory side, but its ready pulse is suppressed.
  - Pending but ungranted reads are not latched, so there is nothing to drop.
  - The buffered or in-flight store is kept; it is already committed.
- d_stall_out = wbuf_valid.

## Timing
- Reset values: all outputs 0; state IDLE; wbuf empty; counter 0; last_d=1.
- Async reset mid-transaction drops enables immediately. The memory must tolerate the abort.
- Read latency: enable sampled at edge N gives m_rd_enable during N..N+1. If m_ready=1 at edge N+1, x_rd_ready and data are high in cycle N+1..N+2. Minimum 2 edges; each memory wait cycle adds 1.
- Store: pulse at edge N fills the buffer. m_wr_enable is high from edge N+1 at the earliest, or later if a transaction is in flight. d_stall_out is high from N until the completing edge.
- Back-to-back: IDLE may re-grant on the completion edge+1. There is no idle bubble beyond the IDLE cycle.
- Simultaneous m_ready and watchdog expiry: m_ready wins, giving normal completion.
- Simultaneous store pulse and WR completion: the new store is captured and d_stall_out stays high.

## Test plan
- Single load, m_ready at the 3rd busy cycle, m_rd_data=0xDEADBEEF -> m_rd_enable high 3 cycles; d_rd_ready one cycle with 0xDEADBEEF; latency 4 edges.
- Fetch and load both held, m_ready always 1, after reset -> grants I,D,I,D; each ready pulse one cycle; no duplicate grant during turnaround.
- Store pulse (addr 0x100, data 0x55, size 2) while a fetch is busy, then load to 0x100 -> WR issued before RD_D; m_wr_size=2; d_stall_out high until WR completes.
- Second store pulse while buffer full and not draining -> dropped; bus_error=1, src=1; first store still written.
- TIMEOUT=4, m_ready stuck 0 on a fetch -> abort after 4 busy cycles; i_rd_ready with data 0; bus_error src=0; next grant proceeds normally.
- flush during RD_D, then reset asserted mid-RD_I -> no d_rd_ready after flush; on reset all outputs 0 immediately, state IDLE.
